// File: rtl/vecadd_arb_pkg.sv
// Shared FSM encoding and default widths for the vector-add round-robin arbiter.
// Element layout: 11 operand pairs of 10 bits in, 11 sums of 11 bits out.
package vecadd_arb_pkg;

    localparam int NUM_ELEM   = 11;
    localparam int IN_ELEM_W  = 10;
    localparam int OUT_ELEM_W = 11;
    localparam int IN_W_DEF   = 2 * NUM_ELEM * IN_ELEM_W;
    localparam int OUT_W_DEF  = NUM_ELEM * OUT_ELEM_W;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/vecadd_rr_pick.sv
// Combinational round-robin picker: the first valid requester strictly after
// last_grant wins, wrapping to the lowest valid index when none is above it.
module vecadd_rr_pick
    import vecadd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    pick,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] masked;
    logic [ID_W-1:0]    pick_hi;
    logic [ID_W-1:0]    pick_lo;

    always_comb begin
        masked  = '0;
        pick_hi = '0;
        pick_lo = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req_valid[i] && (i > int'(last_grant));
        end
        // Walk downwards so the lowest set index is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i])    pick_hi = ID_W'(i);
            if (req_valid[i]) pick_lo = ID_W'(i);
        end
        pick = (|masked) ? pick_hi : pick_lo;
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/vecadd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream vector-add engine among NUM_REQ requesters,
// one transaction in flight. Per-requester saturating counters exist only with VECADD_ARB_STATS_EN.
module vecadd_rr_arbiter
    import vecadd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_REQ*IN_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [OUT_W-1:0]           resp_data,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [IN_W-1:0]            eng_s_data,
    output logic                       eng_s_valid,
    input  logic                       eng_s_ready,
    input  logic [OUT_W-1:0]           eng_m_data,
    input  logic                       eng_m_valid,
    output logic                       eng_m_ready,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ*CNT_W-1:0]   stat_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e          state_q, state_d;
    logic [IN_W-1:0] s_data_q, s_data_d;
    logic            s_valid_q, s_valid_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] pick;
    logic            any_valid;

    vecadd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .pick       (pick),
        .any_valid  (any_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            grant_q   <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            s_data_q  <= s_data_d;
            s_valid_q <= s_valid_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_data_d    = s_data_q;
        s_valid_d   = s_valid_q;
        grant_d     = grant_q;
        last_d      = last_q;
        req_ready   = '0;
        resp_valid  = '0;
        eng_m_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && any_valid) begin
                    req_ready[pick] = 1'b1;
                    s_data_d        = req_data[pick*IN_W +: IN_W];
                    s_valid_d       = 1'b1;
                    grant_d         = pick;
                    state_d         = ST_SEND;
                end
            end
            ST_SEND: begin
                if (eng_s_ready) begin
                    s_valid_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Result path is a pure pass-through to the owning requester.
                eng_m_ready         = resp_ready[grant_q];
                resp_valid[grant_q] = eng_m_valid;
                if (eng_m_valid && resp_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign eng_s_data  = s_data_q;
    assign eng_s_valid = s_valid_q;
    assign resp_data   = eng_m_data;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;

`ifdef VECADD_ARB_STATS_EN
    logic             done;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    assign done = (state_q == ST_WAIT) && eng_m_valid && resp_ready[grant_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (done && (cnt_q[grant_q] != '1)) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_vecadd_rr_arbiter.sv
// Randomized self-checking bench for vecadd_rr_arbiter with a behavioural engine
// and a transaction-level reference model (rotation search, element-wise sums).
module tb_vecadd_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IN_W    = 220;
    localparam int OUT_W   = 121;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NUM_REQ*IN_W-1:0]  req_data;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [OUT_W-1:0]         resp_data;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [IN_W-1:0]          eng_s_data;
    logic                     eng_s_valid;
    logic                     eng_s_ready;
    logic [OUT_W-1:0]         eng_m_data;
    logic                     eng_m_valid;
    logic                     eng_m_ready;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;
    logic [NUM_REQ*CNT_W-1:0] stat_cnt;

    always #5 clk = ~clk;

    vecadd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .resp_data   (resp_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .eng_s_data  (eng_s_data),
        .eng_s_valid (eng_s_valid),
        .eng_s_ready (eng_s_ready),
        .eng_m_data  (eng_m_data),
        .eng_m_valid (eng_m_valid),
        .eng_m_ready (eng_m_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .stat_cnt    (stat_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester side
    logic [IN_W-1:0] op_r [NUM_REQ];
    bit              pending [NUM_REQ];

    // Reference model: one transaction at a time, owner, rotation pointer, counts
    bit              m_infl, m_issued;
    int              m_owner, m_last;
    logic [IN_W-1:0] m_op;
    int              m_cnt [NUM_REQ];

    // Behavioural engine
    bit               e_has;
    int               e_lat;
    logic [OUT_W-1:0] e_res;

    // Phase knobs (percentages)
    logic [NUM_REQ-1:0] req_mask;
    int rate, en_pct, sready_pct, rready_pct, lat_max, drop_pct, glitch_pct, rst_pct;

    function automatic logic [IN_W-1:0] rand_op();
        logic [IN_W-1:0] op;
        op = '0;
        for (int e = 0; e < 22; e++) op[10*e +: 10] = 10'($urandom_range(0, 1023));
        return op;
    endfunction

    function automatic logic [OUT_W-1:0] vec_sum(input logic [IN_W-1:0] op);
        logic [OUT_W-1:0] s;
        int a, b;
        s = '0;
        for (int e = 0; e < 11; e++) begin
            a = int'(op[IN_W-1-10*e -: 10]);
            b = int'(op[IN_W-1-10*(11+e) -: 10]);
            s[OUT_W-1-11*e -: 11] = 11'(a + b);
        end
        return s;
    endfunction

    function automatic int model_pick(input int last, input logic [NUM_REQ-1:0] v);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (last + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int exp_stat(input int i);
`ifdef VECADD_ARB_STATS_EN
        return m_cnt[i];
`else
        return 0 * i;
`endif
    endfunction

    task automatic model_reset();
        m_infl   = 0;
        m_issued = 0;
        m_owner  = 0;
        m_last   = NUM_REQ - 1;
        m_op     = '0;
        for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
        e_has = 0;
        e_lat = 0;
    endtask

    task automatic set_phase(input logic [NUM_REQ-1:0] mask, input int r, input int en, input int sr,
                             input int rr, input int lat, input int drop, input int gl, input int rs);
        req_mask = mask; rate = r; en_pct = en; sready_pct = sr; rready_pct = rr;
        lat_max = lat; drop_pct = drop; glitch_pct = gl; rst_pct = rs;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_mask[i] && !pending[i] && ($urandom_range(0, 99) < rate)) begin
                pending[i] = 1;
                op_r[i]    = rand_op();
            end else if (pending[i] && ($urandom_range(0, 99) < drop_pct)) begin
                pending[i] = 0;
            end
            req_valid[i]               = pending[i];
            req_data[i*IN_W +: IN_W]   = op_r[i];
            resp_ready[i]              = ($urandom_range(0, 99) < rready_pct);
        end
        enable      = ($urandom_range(0, 99) < en_pct);
        eng_s_ready = !e_has && ($urandom_range(0, 99) < sready_pct);
        if (e_has && e_lat == 0) begin
            eng_m_valid = 1'b1;
            eng_m_data  = e_res;
        end else begin
            // Stray result beats only while the engine holds nothing.
            eng_m_valid = !e_has && ($urandom_range(0, 99) < glitch_pct);
            eng_m_data  = OUT_W'({$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    task automatic check_and_step();
        logic [NUM_REQ-1:0] exp_rr, exp_rv;
        logic               exp_mr;
        int                 p;
        exp_rr = '0; exp_rv = '0; exp_mr = 1'b0; p = -1;
        if (!m_infl && enable && (|req_valid)) begin
            p = model_pick(m_last, req_valid);
            exp_rr[p] = 1'b1;
        end
        if (m_infl && m_issued) begin
            exp_mr = resp_ready[m_owner];
            if (eng_m_valid) exp_rv[m_owner] = 1'b1;
        end
        check_val("req_ready", req_ready, exp_rr);
        check_val("busy", busy, m_infl);
        check_val("eng_s_valid", eng_s_valid, m_infl && !m_issued);
        check_val("eng_s_data", eng_s_data, m_op);
        check_val("grant_id", grant_id, m_owner);
        check_val("eng_m_ready", eng_m_ready, exp_mr);
        check_val("resp_valid", resp_valid, exp_rv);
        if (exp_rv != '0) check_val("resp_data", resp_data, vec_sum(m_op));
        for (int i = 0; i < NUM_REQ; i++) check_val("stat_cnt", stat_cnt[i*CNT_W +: CNT_W], exp_stat(i));

        if (eng_s_valid && eng_s_ready) begin
            e_has = 1;
            e_res = vec_sum(eng_s_data);
            e_lat = $urandom_range(0, lat_max);
        end else if (e_has && e_lat > 0) begin
            e_lat--;
        end else if (e_has && eng_m_valid && eng_m_ready) begin
            e_has = 0;
        end

        if (!m_infl) begin
            if (p >= 0) begin
                m_infl     = 1;
                m_issued   = 0;
                m_owner    = p;
                m_op       = op_r[p];
                pending[p] = 0;
            end
        end else if (!m_issued) begin
            if (eng_s_ready) m_issued = 1;
        end else if (eng_m_valid && resp_ready[m_owner]) begin
            m_last = m_owner;
            m_infl = 0;
            if (m_cnt[m_owner] < CNT_MAX) m_cnt[m_owner]++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_eng_s_valid"}, eng_s_valid, 1'b0);
        check_val({tag, "_eng_s_data"}, eng_s_data, '0);
        check_val({tag, "_grant_id"}, grant_id, '0);
        check_val({tag, "_eng_m_ready"}, eng_m_ready, 1'b0);
        check_val({tag, "_resp_valid"}, resp_valid, '0);
        check_val({tag, "_stat_cnt"}, stat_cnt, '0);
    endtask

    task automatic do_reset_mid();
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        model_reset();
        eng_m_valid = 1'b0;
        eng_s_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pending[i]) begin
                pending[i] = 1;
                op_r[i]    = rand_op();
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive();
            if (rst_pct > 0 && m_infl && m_issued && ($urandom_range(0, 99) < rst_pct)) begin
                do_reset_mid();
                drive();
            end
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        resp_ready  = '0;
        eng_s_ready = 1'b0;
        eng_m_valid = 1'b0;
        eng_m_data  = '0;
        e_res       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = 0;
            op_r[i]    = '0;
        end
        model_reset();
        #2;
        check_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single requester, A0=1 B0=2, everything else zero -> S0=3
        set_phase(4'b0001, 0, 100, 100, 100, 0, 0, 0, 0);
        pending[0] = 1;
        op_r[0]    = '0;
        op_r[0][IN_W-1 -: 10]      = 10'd1;
        op_r[0][IN_W-1-110 -: 10]  = 10'd2;
        run(8);

        // All requesters hammering, engine always ready: strict rotation
        set_phase(4'b1111, 100, 100, 100, 100, 0, 0, 0, 0);
        run(40);

        // Even requesters only: wrap-around past the last grant
        set_phase(4'b0101, 100, 100, 100, 100, 1, 0, 0, 0);
        run(30);

        // Slow result consumers: results must be held in WAIT
        set_phase(4'b1111, 80, 100, 100, 10, 2, 0, 0, 0);
        run(150);

        // Asynchronous reset while a result is pending
        set_phase(4'b1111, 70, 100, 80, 30, 3, 0, 5, 30);
        run(200);

        // Requester 3 alone for enough transactions to saturate its counter
        set_phase(4'b1000, 100, 100, 100, 100, 0, 0, 0, 0);
        run(120);

        // Mixed random traffic with enable gaps, drops and stray result beats
        set_phase(4'b1111, 40, 85, 60, 60, 3, 5, 10, 0);
        run(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
